// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle Simple-RISCV datapath: fetch/decode/exec/mem/wb.
// Latency (zero-wait memory): LUI/BEQ 3 cycles, R/ADDI/SW 4, LW 5; memory stalls add cycles.
// Backpressure: mem_req held until mem_ready, trap on MEM_TIMEOUT; PERF_CNT_EN adds perf counters.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_dbg
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    localparam int             CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  LIMIT = CW'(MEM_TIMEOUT);

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_q, wait_d;
    logic [1:0]     trap_q, trap_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_rtype, is_addi, is_load, is_store, is_lui, is_beq;
    logic       rtype_ok;
    logic [CW-1:0] wait_inc;
    logic       timeout_hit;
    logic       unused_instr_bits;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    // Register specifiers are consumed by the datapath, not by this FSM.
    assign unused_instr_bits = ^instr[24:15];

    assign is_rtype = (opcode == OP_R);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_lui   = (opcode == OP_LUI);
    assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    assign rtype_ok = is_rtype && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));

    // The limit is reached on the cycle that would make the wait count equal MEM_TIMEOUT.
    assign wait_inc    = wait_q + 1'b1;
    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_inc == LIMIT);

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        trap_d  = trap_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = TRAP_TIMEOUT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                if (rtype_ok || is_addi || is_load || is_store) begin
                    state_d = S_EXEC;
                end else if (is_lui) begin
                    state_d = S_WB;
                end else if (is_beq) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = TRAP_ILLEGAL;
                end
            end
            S_EXEC: begin
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = TRAP_TIMEOUT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
        end
    end

    // Outputs decode straight from the state flop so reset takes effect without a clock.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'b00;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd1;
            end
            S_EXEC: begin
                if (is_rtype) begin
                    alu_src_b = 2'd0;
                    alu_op    = 2'b10;
                end else if (is_addi) begin
                    alu_src_b = 2'd1;
                    alu_op    = 2'b10;
                end else begin
                    alu_src_b = 2'd1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_store;
            end
            S_WB: begin
                reg_we = (rd != 5'd0);
                if (is_load) begin
                    wb_sel = 2'd1;
                end else if (is_lui) begin
                    wb_sel = 2'd2;
                end
            end
            S_BRANCH: begin
                alu_op = 2'b01;
                if (zero) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign trap_cause = trap_q;
    assign state_dbg  = state_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_WB) || (state_q == S_MEM) || (state_q == S_BRANCH));

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (state_q != S_TRAP) begin
            cycle_d = cycle_q + 32'd1;
        end
        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, reg_we;
    logic [1:0]  alu_src_b, alu_op, wb_sel, trap_cause;
    logic [2:0]  state_dbg;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .trap_cause (trap_cause),
        .state_dbg  (state_dbg)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One controller cycle: release reset, drive inputs on the falling edge, settle.
    task automatic cyc(input logic rdy, input logic z);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        chk("rst_trap", {30'd0, trap_cause}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        instr     = 32'h00500093;
        #1;
        chk("rst_state", {29'd0, state_dbg}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rst_ir_we", {31'd0, ir_we}, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_trap", {30'd0, trap_cause}, 32'd0);

        // ADDI x1,x0,5
        cyc(1'b1, 1'b0);
        chk("addi_f_state", {29'd0, state_dbg}, 32'd0);
        chk("addi_f_ir_we", {31'd0, ir_we}, 32'd1);
        chk("addi_f_pc_we", {31'd0, pc_we}, 32'd1);
        chk("addi_f_pc_src", {31'd0, pc_src}, 32'd0);
        chk("addi_f_src_a", {31'd0, alu_src_a}, 32'd1);
        chk("addi_f_src_b", {30'd0, alu_src_b}, 32'd2);
        cyc(1'b0, 1'b0);
        chk("addi_d_state", {29'd0, state_dbg}, 32'd1);
        chk("addi_d_src_b", {30'd0, alu_src_b}, 32'd1);
        chk("addi_d_mem_req", {31'd0, mem_req}, 32'd0);
        cyc(1'b0, 1'b0);
        chk("addi_e_state", {29'd0, state_dbg}, 32'd2);
        chk("addi_e_src_a", {31'd0, alu_src_a}, 32'd0);
        chk("addi_e_src_b", {30'd0, alu_src_b}, 32'd1);
        chk("addi_e_alu_op", {30'd0, alu_op}, 32'd2);
        cyc(1'b0, 1'b0);
        chk("addi_wb_state", {29'd0, state_dbg}, 32'd4);
        chk("addi_wb_reg_we", {31'd0, reg_we}, 32'd1);
        chk("addi_wb_sel", {30'd0, wb_sel}, 32'd0);

        // LW x2,0(x1) with a 3-cycle data wait
        cyc(1'b1, 1'b0);
        instr = 32'h0000A103;
        chk("lw_f_state", {29'd0, state_dbg}, 32'd0);
        cyc(1'b0, 1'b0);
        chk("lw_d_state", {29'd0, state_dbg}, 32'd1);
        cyc(1'b0, 1'b0);
        chk("lw_e_state", {29'd0, state_dbg}, 32'd2);
        chk("lw_e_alu_op", {30'd0, alu_op}, 32'd0);
        chk("lw_e_src_b", {30'd0, alu_src_b}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc((i == 3) ? 1'b1 : 1'b0, 1'b0);
            chk("lw_m_state", {29'd0, state_dbg}, 32'd3);
            chk("lw_m_mem_req", {31'd0, mem_req}, 32'd1);
            chk("lw_m_iord", {31'd0, iord}, 32'd1);
            chk("lw_m_mem_we", {31'd0, mem_we}, 32'd0);
        end
        cyc(1'b0, 1'b0);
        chk("lw_wb_state", {29'd0, state_dbg}, 32'd4);
        chk("lw_wb_sel", {30'd0, wb_sel}, 32'd1);
        chk("lw_wb_reg_we", {31'd0, reg_we}, 32'd1);

        // BEQ x0,x0,+8 taken
        cyc(1'b1, 1'b0);
        instr = 32'h00000463;
        chk("beq_f_state", {29'd0, state_dbg}, 32'd0);
        cyc(1'b0, 1'b0);
        chk("beq_d_state", {29'd0, state_dbg}, 32'd1);
        cyc(1'b0, 1'b1);
        chk("beq_t_state", {29'd0, state_dbg}, 32'd5);
        chk("beq_t_pc_we", {31'd0, pc_we}, 32'd1);
        chk("beq_t_pc_src", {31'd0, pc_src}, 32'd1);
        chk("beq_t_alu_op", {30'd0, alu_op}, 32'd1);
        chk("beq_t_src_b", {30'd0, alu_src_b}, 32'd0);
        // BEQ not taken
        cyc(1'b1, 1'b0);
        chk("beq_nt_f_state", {29'd0, state_dbg}, 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("beq_nt_state", {29'd0, state_dbg}, 32'd5);
        chk("beq_nt_pc_we", {31'd0, pc_we}, 32'd0);
        chk("beq_nt_pc_src", {31'd0, pc_src}, 32'd0);

        // ADD x3,x1,x2
        cyc(1'b1, 1'b0);
        instr = 32'h002081B3;
        chk("add_f_state", {29'd0, state_dbg}, 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("add_e_state", {29'd0, state_dbg}, 32'd2);
        chk("add_e_src_b", {30'd0, alu_src_b}, 32'd0);
        chk("add_e_alu_op", {30'd0, alu_op}, 32'd2);
        cyc(1'b0, 1'b0);
        chk("add_wb_reg_we", {31'd0, reg_we}, 32'd1);

        // ADDI x0,x0,1: rd=0 suppresses the write
        cyc(1'b1, 1'b0);
        instr = 32'h00100013;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("x0_wb_state", {29'd0, state_dbg}, 32'd4);
        chk("x0_wb_reg_we", {31'd0, reg_we}, 32'd0);

        // SW x2,0(x1) aborted by reset mid-MEM
        cyc(1'b1, 1'b0);
        instr = 32'h0020A023;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("sw_e_alu_op", {30'd0, alu_op}, 32'd0);
        cyc(1'b0, 1'b0);
        chk("sw_m_state", {29'd0, state_dbg}, 32'd3);
        chk("sw_m_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw_m_iord", {31'd0, iord}, 32'd1);
        rst = 1'b1;
        #1;
        chk("sw_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("sw_rst_iord", {31'd0, iord}, 32'd0);
        chk("sw_rst_state", {29'd0, state_dbg}, 32'd0);

        // Illegal instruction 0xFFFFFFFF
        cyc(1'b1, 1'b0);
        instr = 32'hFFFFFFFF;
        chk("ill_f_ir_we", {31'd0, ir_we}, 32'd1);
        cyc(1'b0, 1'b0);
        chk("ill_d_state", {29'd0, state_dbg}, 32'd1);
        cyc(1'b0, 1'b0);
        chk("ill_t_state", {29'd0, state_dbg}, 32'd6);
        chk("ill_t_trap", {30'd0, trap_cause}, 32'd1);
        chk("ill_t_mem_req", {31'd0, mem_req}, 32'd0);
        cyc(1'b1, 1'b0);
        chk("ill_hold_state", {29'd0, state_dbg}, 32'd6);
        chk("ill_hold_mem_req", {31'd0, mem_req}, 32'd0);
        chk("ill_hold_ir_we", {31'd0, ir_we}, 32'd0);
        do_reset();

        // R-type with an unsupported funct7
        cyc(1'b1, 1'b0);
        instr = 32'h20000033;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("f7_t_state", {29'd0, state_dbg}, 32'd6);
        chk("f7_t_trap", {30'd0, trap_cause}, 32'd1);
        do_reset();

        // Fetch timeout: 16 waiting cycles then TRAP
        instr = 32'h000010B7;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0);
            chk("to_wait_state", {29'd0, state_dbg}, 32'd0);
            chk("to_wait_mem_req", {31'd0, mem_req}, 32'd1);
        end
        cyc(1'b0, 1'b0);
        chk("to_state", {29'd0, state_dbg}, 32'd6);
        chk("to_trap", {30'd0, trap_cause}, 32'd2);
        chk("to_mem_req", {31'd0, mem_req}, 32'd0);
        do_reset();

        // mem_ready on the 16th cycle wins over the limit; LUI follows
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0);
        chk("lim_state", {29'd0, state_dbg}, 32'd0);
        chk("lim_ir_we", {31'd0, ir_we}, 32'd1);
        cyc(1'b0, 1'b0);
        chk("lim_d_state", {29'd0, state_dbg}, 32'd1);
        chk("lim_trap", {30'd0, trap_cause}, 32'd0);
        cyc(1'b0, 1'b0);
        chk("lui_wb_state", {29'd0, state_dbg}, 32'd4);
        chk("lui_wb_sel", {30'd0, wb_sel}, 32'd2);
        chk("lui_wb_reg_we", {31'd0, reg_we}, 32'd1);
        cyc(1'b0, 1'b0);
        chk("lui_next_state", {29'd0, state_dbg}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences the multi-cycle Simple-RISCV datapath: instruction fetch, decode, execute, memory and writeback.
- Decodes the latched IR for the supported subset: R-type ADD/SUB, ADDI, LW, SW, LUI and BEQ.
- Drives datapath mux selects and write strobes, and the handshake to the shared instruction/data memory.
- Sits between the IR/regfile/ALU/imm-gen datapath and the unified memory port. Traps on illegal opcodes or memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before trapping; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr  in  32  IR contents; stable from DECODE until the next FETCH completes
zero  in  1  ALU zero flag
mem_ready  in  1  memory completion strobe for the current request
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable (valid with mem_req)
iord  out  1  address select: 0 = PC, 1 = ALUOut
ir_we  out  1  IR/old_pc load strobe
pc_we  out  1  PC write strobe
pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
alu_src_a  out  1  0 = rs1, 1 = old_pc
alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
alu_op  out  2  00 = add, 01 = sub, 10 = per funct3/funct7
reg_we  out  1  register-file write strobe
wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = imm (LUI)
trap_cause  out  2  00 none, 01 illegal, 10 memory timeout; sticky
state_dbg  out  3  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, TRAP=6.
- On rst: state=FETCH, wait counter=0, trap_cause=00. Outputs follow state immediately (async), so mem_req=1 and all strobes=0.
- Every output not listed for a state is 0 in that state.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=1, alu_src_b=2, alu_op=00.
  - In the mem_ready cycle: ir_we=1, pc_we=1, pc_src=0; next state DECODE.
  - Without mem_ready: stay in FETCH.
- DECODE:
  - Outputs: alu_src_a=1, alu_src_b=1, alu_op=00, so the datapath latches the branch target old_pc+imm into ALUOut.
  - Opcode 0110011/0010011/0000011/0100011 -> EXEC.
  - Opcode 0110111 -> WB.
  - Opcode 1100011 with funct3=000 -> BRANCH.
  - Anything else -> TRAP with trap_cause=01. This includes an R-type whose funct7 is neither 0000000 nor 0100000, and BEQ-opcode with funct3 != 000.
- EXEC:
  - R-type: alu_src_a=0, alu_src_b=0, alu_op=10 -> WB.
  - ADDI: alu_src_a=0, alu_src_b=1, alu_op=10 -> WB.
  - LW/SW: alu_src_a=0, alu_src_b=1, alu_op=00 -> MEM.
- MEM:
  - Outputs: mem_req=1, iord=1, mem_we=1 for SW only.
  - On mem_ready: SW -> FETCH; LW -> WB (datapath captures MDR on mem_ready).
- WB:
  - Outputs: reg_we=1 for exactly one cycle. wb_sel = 0 for R/ADDI, 1 for LW, 2 for LUI.
  - If rd (instr[11:7]) = 0, reg_we is forced 0.
  - Next state FETCH.
- BRANCH:
  - Outputs: alu_src_a=0, alu_src_b=0, alu_op=01.
  - If zero=1: pc_we=1, pc_src=1.
  - Next state FETCH unconditionally.
- TRAP: all strobes and mem_req are 0. State is held until rst.
- Handshake rules:
  - mem_req, mem_we and iord remain constant while waiting.
  - mem_ready sampled while mem_req=0 is ignored.
  - mem_ready arriving in the same cycle as request assertion counts as zero-wait.
- Wait counter:
  - Increments each cycle in FETCH/MEM while mem_ready=0; clears on mem_ready or on a state change.
  - When the counter equals MEM_TIMEOUT (MEM_TIMEOUT>0) with mem_ready still 0: next state TRAP, trap_cause=10.
  - mem_ready in the same cycle as the limit wins (no trap).
- Latency with zero-wait memory: LUI 3 cycles, BEQ 3, R/ADDI 4, SW 4, LW 5.
- Reset asserted mid-MEM aborts the access: mem_we and iord drop asynchronously and FETCH restarts.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle not in TRAP.
  - instret_cnt increments on each transition into FETCH from WB, MEM (SW) or BRANCH.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready tied 1 -> states 0,1,2,4,0; EXEC alu_src_b=1, alu_op=10; WB reg_we=1, wb_sel=0.
- LW x2,0(x1) (0x0000A103), data mem_ready delayed 3 cycles -> MEM holds mem_req=1, iord=1, mem_we=0 for 4 cycles; then WB wb_sel=1, reg_we=1.
- BEQ x0,x0,+8 (0x00000463):
  - zero=1 -> BRANCH pc_we=1, pc_src=1.
  - Repeat with zero=0 -> pc_we=0; FETCH follows in both cases.
- 0xFFFFFFFF fetched -> DECODE->TRAP, trap_cause=01, mem_req=0 thereafter; rst pulse -> FETCH, trap_cause=00.
- FETCH with mem_ready held 0, MEM_TIMEOUT=16 -> TRAP after 16 waiting cycles, trap_cause=10. Second run with mem_ready=1 on the 16th cycle -> DECODE, no trap.
- ADDI x0,x0,1 (0x00100013) -> WB reg_we=0. SW mid-MEM with rst asserted -> mem_we drops the same cycle, state_dbg=0.
